cmdspi_gen: RTL and testbench

Parametrised command-SPI slave bridging an external SPI master into the on-chip register bus. A frame is a header (R/W bit plus ADDR_W-bit address) followed by DATA_W-bit data words, MSB first. All SPI pins are oversampled in the `clk` domain. An optional burst mode auto-increments the address for consecutive words within one CSN assertion.

---
 rtl/cmdspi_gen.sv | 99 +++++++++
 tb/tb_cmdspi_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cmdspi_gen.sv
// cmdspi_gen: command-SPI slave (CPOL=1) bridging an oversampled SPI master onto a register bus.
// Define CMDSPI_BURST_EN to enable address auto-increment across consecutive words in one CSN assertion.
`timescale 1ns/1ps
module cmdspi_gen #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CSN,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              we,
  output logic              re,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rdat,
  output logic [DATA_W-1:0] wdat
);
`ifdef CMDSPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int CW = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] cs_s, sck_s, mo_s;
  logic cs_q, sck_q, cs, mosi, rise, fall, cs_fall, hdr_done, word_done, wr, first, ld;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] rx, rx_n, tx;
  assign cs      = cs_s[SYNC_STAGES-1];
  assign mosi    = mo_s[SYNC_STAGES-1];
  assign rise    = sck_s[SYNC_STAGES-1] & ~sck_q;
  assign fall    = ~sck_s[SYNC_STAGES-1] & sck_q;
  assign cs_fall = ~cs & cs_q;
  // CSN sync resets to "selected" so a frame still in flight at reset release never looks like a fresh CSN fall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cs_s  <= '0;
      sck_s <= '1;
      mo_s  <= '0;
      cs_q  <= 1'b0;
      sck_q <= 1'b1;
    end else begin
      cs_s  <= {cs_s[SYNC_STAGES-2:0], CSN};
      sck_s <= {sck_s[SYNC_STAGES-2:0], SCLK};
      mo_s  <= {mo_s[SYNC_STAGES-2:0], MOSI};
      cs_q  <= cs;
      sck_q <= sck_s[SYNC_STAGES-1];
    end
  always_comb begin
    rx_n      = {rx[DATA_W-2:0], mosi};
    hdr_done  = state == HDR && rise && cnt == CW'(ADDR_W);
    word_done = state == DATA && rise && cnt == CW'(DATA_W-1);
    state_n   = cs ? IDLE :
                (state == IDLE && cs_fall) ? HDR :
                hdr_done ? DATA :
                (word_done && !BURST) ? DONE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rx    <= '0;
      tx    <= '0;
      wr    <= 1'b0;
      first <= 1'b0;
      ld    <= 1'b0;
      MISO  <= 1'b0;
      we    <= 1'b0;
      re    <= 1'b0;
      addr  <= '0;
      wdat  <= '0;
    end else begin
      state <= state_n;
      we    <= word_done && wr;
      re    <= (hdr_done && !rx_n[ADDR_W]) || (word_done && BURST && !wr);
      ld    <= re;
      if (rise) rx <= rx_n;
      cnt <= (cs_fall || hdr_done || word_done) ? '0 :
             (rise && (state == HDR || state == DATA)) ? cnt + 1'b1 : cnt;
      if (hdr_done) begin
        wr    <= rx_n[ADDR_W];
        first <= 1'b1;
        addr  <= rx_n[ADDR_W-1:0];
      end
      // the first written word uses the header address; every later word (and every read prefetch) steps it
      if (word_done) begin
        first <= 1'b0;
        if (wr) wdat <= rx_n;
        if (BURST && (!wr || !first)) addr <= addr + 1'b1;
      end
      if (ld) tx <= rdat;
      else if (fall && state == DATA && !wr) tx <= tx << 1;
      MISO <= (state != DATA || wr) ? 1'b0 : (fall ? tx[DATA_W-1] : MISO);
    end
endmodule

// File: tb/tb_cmdspi_gen.sv
// tb_cmdspi_gen: randomized frames against a frame-level reference model of cmdspi_gen.
`timescale 1ns/1ps
module tb_cmdspi_gen;
  localparam int AW = 7, DW = 32, H = 50, HL = AW + 1;
`ifdef CMDSPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  logic clk = 0, rst = 0, csn = 1, sclk = 1, mosi = 0;
  logic miso, we, re;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdat, wdat;
  logic [DW-1:0] rmem [2**AW];
  int n_cmp = 0, n_err = 0;
  logic [AW-1:0] wa_q[$], ra_q[$];
  logic [DW-1:0] wd_q[$];
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdat = '0;
  logic we_d = 0, re_d = 0;
  always #5 clk = ~clk;
  assign rdat = rmem[addr];
  cmdspi_gen dut (
    .clk(clk), .rst(rst), .CSN(csn), .SCLK(sclk), .MOSI(mosi), .MISO(miso),
    .we(we), .re(re), .addr(addr), .rdat(rdat), .wdat(wdat)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (we) begin
      wa_q.push_back(addr);
      wd_q.push_back(wdat);
    end
    if (re) ra_q.push_back(addr);
    if (we | re) chk("strobe_excl_width", 64'({we & re, we & we_d, re & re_d}), 64'(0));
    we_d <= we;
    re_d <= re;
  end
  task automatic frame(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] w0,
                       input logic [DW-1:0] w1, input int nw, input int nbits_in, input int rst_at);
    bit q[$];
    bit mb[$];
    logic [DW-1:0] wd[$];
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    logic [63:0] g, e;
    int full, n, k, nbits;
    bit hit_rst, eb;
    wd.push_back(w0);
    if (nw > 1) wd.push_back(w1);
    for (int j = 2; j < nw; j++) wd.push_back($urandom);
    q.push_back(w);
    for (int i = AW - 1; i >= 0; i--) q.push_back(a[i]);
    foreach (wd[j]) for (int i = DW - 1; i >= 0; i--) q.push_back(wd[j][i]);
    nbits = nbits_in > q.size() ? q.size() : nbits_in;
    hit_rst = rst_at >= 0 && rst_at < nbits;
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    @(negedge clk);
    csn = 0;
    #(H);
    for (int i = 0; i < nbits; i++) begin
      sclk = 0;
      mosi = q[i];
      #(H);
      mb.push_back(miso);
      sclk = 1;
      #(H);
      if (i == rst_at) begin
        rst = 1;
        #1;
        chk("rst_outputs", 64'({miso, we, re, addr, wdat}), 64'(0));
        repeat (3) @(negedge clk);
        rst = 0;
      end
    end
    csn = 1;
    repeat (20) @(negedge clk);
    full = nbits >= HL ? (nbits - HL) / DW : -1;
    if (hit_rst) begin
      m_addr = '0;
      m_wdat = '0;
    end else if (full >= 0) begin
      if (w) begin
        n = BURST ? full : (full > 0 ? 1 : 0);
        for (int j = 0; j < n; j++) begin
          ea.push_back(AW'(a + j));
          ed.push_back(wd[j]);
        end
        m_addr = AW'(a + (n > 0 ? n - 1 : 0));
        if (n > 0) m_wdat = wd[n-1];
      end else begin
        n = BURST ? full + 1 : 1;
        for (int j = 0; j < n; j++) ea.push_back(AW'(a + j));
        m_addr = AW'(a + n - 1);
      end
    end
    if (w) begin
      chk("we_count", 64'(wa_q.size()), 64'(ea.size()));
      chk("re_count_wr", 64'(ra_q.size()), 64'(0));
      for (int j = 0; j < ea.size() && j < wa_q.size(); j++) begin
        chk("we_addr", 64'(wa_q[j]), 64'(ea[j]));
        chk("we_wdat", 64'(wd_q[j]), 64'(ed[j]));
      end
    end else begin
      chk("re_count", 64'(ra_q.size()), 64'(ea.size()));
      chk("we_count_rd", 64'(wa_q.size()), 64'(0));
      for (int j = 0; j < ea.size() && j < ra_q.size(); j++) chk("re_addr", 64'(ra_q[j]), 64'(ea[j]));
    end
    g = '0;
    e = '0;
    for (int i = 0; i < nbits; i++) begin
      eb = 1'b0;
      if (!w && !hit_rst && i >= HL) begin
        k = (i - HL) / DW;
        if (BURST || k == 0) eb = rmem[AW'(a + k)][DW - 1 - (i - HL) % DW];
      end
      g = {g[62:0], mb[i]};
      e = {e[62:0], eb};
      if (i == HL - 1 || i == nbits - 1 || (i >= HL && (i - HL) % DW == DW - 1)) begin
        chk("miso_chunk", g, e);
        g = '0;
        e = '0;
      end
    end
    chk("addr_hold", 64'(addr), 64'(m_addr));
    chk("wdat_hold", 64'(wdat), 64'(m_wdat));
    chk("miso_idle", 64'(miso), 64'(0));
  endtask
  initial begin
    bit rw;
    int nw, tot;
    foreach (rmem[i]) rmem[i] = $urandom;
    rmem[1] = 32'hA5A5A5A5;
    rmem[0] = 32'h5A5A5A5A;
    rmem[7'h7F] = 32'h5A5A5A5A;
    #1 rst = 1;
    #1 chk("reset_state", 64'({miso, we, re, addr, wdat}), 64'(0));
    repeat (4) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    frame(0, 7'h01, 32'h12345678, 0, 1, 40, -1);
    frame(1, 7'h02, 32'h12345678, 0, 1, 40, -1);
    frame(1, 7'h02, 32'hDEADBEEF, 0, 1, 20, -1);
    frame(0, 7'h01, 32'h0, 0, 1, 40, -1);
    frame(1, 7'h05, 32'h11111111, 32'h22222222, 2, 72, -1);
    frame(0, 7'h7F, 32'h0, 0, 2, 72, -1);
    frame(1, 7'h02, 32'hCAFEF00D, 0, 1, 40, 30);
    frame(1, 7'h03, 32'h0BADF00D, 0, 1, 40, -1);
    frame(0, 7'h01, 32'h0, 0, 1, 40, -1);
    repeat (25) begin
      rw  = 1'($urandom_range(0, 1));
      nw  = $urandom_range(1, 3);
      tot = HL + nw * DW;
      frame(rw, AW'($urandom), $urandom, $urandom, nw,
            $urandom_range(0, 3) == 0 ? $urandom_range(1, tot) : tot, -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
